// File: rtl/pmod_io_adapter.sv
// Pad-side adapter: registers the video path onto the Tiny VGA PMOD pinout with
// optional 2x2 ordered dithering, and synchronises the SPI pins on the bidirectional PMOD.
module pmod_io_adapter #(
    parameter int COLOR_BITS    = 4,
    parameter int DITHER        = 1,
    parameter int HSYNC_POL     = 0,
    parameter int VSYNC_POL     = 0,
    parameter int SYNC_STAGES   = 2,
    parameter int MISO_TRISTATE = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3*COLOR_BITS-1:0] rgb_in,
    input  logic                    de_in,
    input  logic                    hsync_in,
    input  logic                    vsync_in,
    input  logic                    next_vertical_in,
    input  logic                    next_frame_in,
    input  logic                    spi_miso,
    output logic [7:0]              uo_out,
    input  logic [7:0]              uio_in,
    output logic [7:0]              uio_out,
    output logic [7:0]              uio_oe,
    output logic                    spi_cs_s,
    output logic                    spi_mosi_s,
    output logic                    spi_sclk_rise,
    output logic                    spi_sclk_fall
);

    localparam logic HS_INV = (HSYNC_POL == 0);
    localparam logic VS_INV = (VSYNC_POL == 0);

    logic       x_par, y_par, de_prev;
    logic [1:0] thresh;
    logic [1:0] r_q, g_q, b_q;
    logic       hs_q, vs_q, nv_q, nf_q;

    // Bayer 2x2 threshold, indexed [y_par][x_par] = {{0,2},{3,1}}
    always_comb begin
        thresh = 2'd0;
        case ({y_par, x_par})
            2'b00:   thresh = 2'd0;
            2'b01:   thresh = 2'd2;
            2'b10:   thresh = 2'd3;
            default: thresh = 2'd1;
        endcase
    end

    for (genvar ch = 0; ch < 3; ch++) begin : g_chan
        logic [COLOR_BITS-1:0] c;
        logic [1:0]            q;
        logic [1:0]            f;
        logic [1:0]            lvl;

        assign c = rgb_in[ch*COLOR_BITS +: COLOR_BITS];
        assign q = c[COLOR_BITS-1 -: 2];

        if (COLOR_BITS >= 4) begin : g_f4
            assign f = c[COLOR_BITS-3 -: 2];
        end else if (COLOR_BITS == 3) begin : g_f3
            assign f = {c[0], 1'b0};
        end else begin : g_f2
            assign f = 2'b00;
        end

        // Round up only below full scale so the level saturates instead of wrapping
        always_comb begin
            lvl = q;
            if (DITHER != 0 && f > thresh && q != 2'b11)
                lvl = q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q     <= 2'b00;
            g_q     <= 2'b00;
            b_q     <= 2'b00;
            hs_q    <= HS_INV;
            vs_q    <= VS_INV;
            nv_q    <= 1'b0;
            nf_q    <= 1'b0;
            x_par   <= 1'b0;
            y_par   <= 1'b0;
            de_prev <= 1'b0;
        end else begin
            r_q     <= de_in ? g_chan[2].lvl : 2'b00;
            g_q     <= de_in ? g_chan[1].lvl : 2'b00;
            b_q     <= de_in ? g_chan[0].lvl : 2'b00;
            hs_q    <= hsync_in ^ HS_INV;
            vs_q    <= vsync_in ^ VS_INV;
            nv_q    <= next_vertical_in;
            nf_q    <= next_frame_in;
            x_par   <= de_in ? ~x_par : 1'b0;
            de_prev <= de_in;
            if (vsync_in)
                y_par <= 1'b0;
            else if (de_prev && !de_in)
                y_par <= ~y_par;
        end
    end

    assign uo_out = {hs_q, b_q[0], g_q[0], r_q[0], vs_q, b_q[1], g_q[1], r_q[1]};

    logic [SYNC_STAGES-1:0] cs_sync, mosi_sync, sclk_sync;
    logic                   sclk_d;

    // CS chain resets high so the link starts deselected
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_sync <= '0;
            sclk_d    <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], uio_in[0]};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], uio_in[1]};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], uio_in[3]};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
        end
    end

    assign spi_cs_s      = cs_sync[SYNC_STAGES-1];
    assign spi_mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign spi_sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_d & ~spi_cs_s;
    assign spi_sclk_fall = ~sclk_sync[SYNC_STAGES-1] & sclk_d & ~spi_cs_s;

    logic miso_oe;
    assign miso_oe = (MISO_TRISTATE != 0) ? ~spi_cs_s : 1'b1;

    assign uio_out = {2'b00, nf_q, nv_q, 1'b0, spi_miso, 2'b00};
    assign uio_oe  = {2'b00, 2'b11, 1'b0, miso_oe, 2'b00};

    logic unused_pins;
    assign unused_pins = &{1'b0, uio_in[7:4], uio_in[2]};

endmodule

// File: tb/tb_pmod_io_adapter.sv
// Directed bench for pmod_io_adapter: one truncating instance with default polarities and
// a dithering instance with active-high hsync, 3-stage sync and always-driven MISO.
module tb_pmod_io_adapter;

    logic        clk = 1'b0;
    logic        clk_run = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] rgb_in = '0;
    logic        de_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
    logic        next_vertical_in = 1'b0, next_frame_in = 1'b0, spi_miso = 1'b0;
    logic [7:0]  uio_in = 8'h01;

    logic [7:0] uo_a, uio_out_a, uio_oe_a;
    logic       cs_a, mosi_a, rise_a, fall_a;
    logic [7:0] uo_b, uio_out_b, uio_oe_b;
    logic       cs_b, mosi_b, rise_b, fall_b;

    int checks = 0;
    int errors = 0;

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    pmod_io_adapter #(.COLOR_BITS(4), .DITHER(0)) dut_a (
        .clk(clk), .reset(reset), .rgb_in(rgb_in), .de_in(de_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .next_vertical_in(next_vertical_in), .next_frame_in(next_frame_in),
        .spi_miso(spi_miso), .uo_out(uo_a), .uio_in(uio_in), .uio_out(uio_out_a),
        .uio_oe(uio_oe_a), .spi_cs_s(cs_a), .spi_mosi_s(mosi_a),
        .spi_sclk_rise(rise_a), .spi_sclk_fall(fall_a)
    );

    pmod_io_adapter #(.COLOR_BITS(4), .DITHER(1), .HSYNC_POL(1), .VSYNC_POL(0),
                      .SYNC_STAGES(3), .MISO_TRISTATE(0)) dut_b (
        .clk(clk), .reset(reset), .rgb_in(rgb_in), .de_in(de_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .next_vertical_in(next_vertical_in), .next_frame_in(next_frame_in),
        .spi_miso(spi_miso), .uo_out(uo_b), .uio_in(uio_in), .uio_out(uio_out_b),
        .uio_oe(uio_oe_b), .spi_cs_s(cs_b), .spi_mosi_s(mosi_b),
        .spi_sclk_rise(rise_b), .spi_sclk_fall(fall_b)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset with the clock stopped
        #2 reset = 1'b1;
        #2;
        check("rst_uo_a", uo_a, 8'h88);
        check("rst_uo_b", uo_b, 8'h08);
        check("rst_uio_out_a", uio_out_a, 8'h00);
        check("rst_uio_oe_a", uio_oe_a, 8'h30);
        check("rst_uio_oe_b", uio_oe_b, 8'h34);
        check("rst_strobes_a", {6'd0, rise_a, fall_a}, 8'h00);
        check("rst_cs_a", {7'd0, cs_a}, 8'h01);
        check("rst_cs_b", {7'd0, cs_b}, 8'h01);

        clk_run = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // truncate / dither at t=0 give the same levels for F84
        rgb_in = 12'hF84; de_in = 1'b1;
        tick();
        check("trunc_a", uo_a, 8'hDB);
        check("trunc_b", uo_b, 8'h5B);
        de_in = 1'b0;
        tick();
        check("blank_a", uo_a, 8'h88);
        check("blank_b", uo_b, 8'h08);

        // sync polarity; vsync also clears y_par
        hsync_in = 1'b1; vsync_in = 1'b1;
        tick();
        check("pol_a", uo_a, 8'h00);
        check("pol_b", uo_b, 8'h80);
        hsync_in = 1'b0; vsync_in = 1'b0;

        // 2x2 dither block: R=G=0110, B=1111
        rgb_in = 12'h66F; de_in = 1'b1;
        tick();
        check("dith_l0p0_b", uo_b, 8'h4F);
        check("dith_l0p0_a", uo_a, 8'hFC);
        tick();
        check("dith_l0p1_b", uo_b, 8'h7C);
        check("dith_l0p1_a", uo_a, 8'hFC);
        de_in = 1'b0;
        tick();
        check("dith_hblank_b", uo_b, 8'h08);
        de_in = 1'b1;
        tick();
        check("dith_l1p0_b", uo_b, 8'h7C);
        tick();
        check("dith_l1p1_b", uo_b, 8'h4F);
        de_in = 1'b0;
        tick();
        check("dith_end_b", uo_b, 8'h08);

        // status strobes
        next_vertical_in = 1'b1;
        tick();
        check("nv_a", uio_out_a, 8'h10);
        next_vertical_in = 1'b0; next_frame_in = 1'b1;
        tick();
        check("nf_b", uio_out_b, 8'h20);
        next_frame_in = 1'b0;
        tick();

        // MISO pass-through and output enable
        spi_miso = 1'b1;
        #1;
        check("miso_a", uio_out_a, 8'h04);
        check("oe_cs_hi_a", uio_oe_a, 8'h30);
        uio_in = 8'h02;
        tick();
        check("cs_1edge_a", {7'd0, cs_a}, 8'h01);
        check("oe_1edge_a", uio_oe_a, 8'h30);
        tick();
        check("cs_2edge_a", {7'd0, cs_a}, 8'h00);
        check("mosi_2edge_a", {7'd0, mosi_a}, 8'h01);
        check("oe_cs_lo_a", uio_oe_a, 8'h34);
        check("cs_2edge_b", {7'd0, cs_b}, 8'h01);
        tick();
        check("cs_3edge_b", {7'd0, cs_b}, 8'h00);
        check("mosi_3edge_b", {7'd0, mosi_b}, 8'h01);
        check("oe_b", uio_oe_b, 8'h34);
        spi_miso = 1'b0;
        #1;
        check("miso_low_a", uio_out_a, 8'h00);

        // SCLK rise then fall with CS low
        uio_in = 8'h0A;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("rise_a_%0d", k), {7'd0, rise_a}, (k == 2) ? 8'h01 : 8'h00);
            check($sformatf("rise_b_%0d", k), {7'd0, rise_b}, (k == 3) ? 8'h01 : 8'h00);
            check($sformatf("nofall_%0d", k), {6'd0, fall_a, fall_b}, 8'h00);
        end
        uio_in = 8'h02;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("fall_a_%0d", k), {7'd0, fall_a}, (k == 2) ? 8'h01 : 8'h00);
            check($sformatf("fall_b_%0d", k), {7'd0, fall_b}, (k == 3) ? 8'h01 : 8'h00);
            check($sformatf("norise_%0d", k), {6'd0, rise_a, rise_b}, 8'h00);
        end

        // CS high: no strobes
        uio_in = 8'h01;
        for (int k = 0; k < 4; k++) tick();
        uio_in = 8'h09;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("cs_hi_rise_%0d", k), {6'd0, rise_a, rise_b}, 8'h00);
        end
        uio_in = 8'h01;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("cs_hi_fall_%0d", k), {6'd0, fall_a, fall_b}, 8'h00);
        end

        // SCLK edge coincident with CS deassertion is suppressed
        uio_in = 8'h00;
        for (int k = 0; k < 4; k++) tick();
        uio_in = 8'h09;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("coinc_%0d", k), {4'd0, rise_a, rise_b, fall_a, fall_b}, 8'h00);
        end
        check("coinc_cs_a", {7'd0, cs_a}, 8'h01);

        // mid-frame reset without a clock
        rgb_in = 12'hF84; de_in = 1'b1; next_vertical_in = 1'b1;
        tick();
        check("pre_rst_a", uo_a, 8'hDB);
        clk_run = 1'b0;
        reset = 1'b1;
        #1;
        check("mid_rst_uo_a", uo_a, 8'h88);
        check("mid_rst_uo_b", uo_b, 8'h08);
        check("mid_rst_uio_a", uio_out_a, 8'h00);
        check("mid_rst_cs_b", {7'd0, cs_b}, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
